// File: rtl/ram_sync.sv
// Single-port synchronous RAM with byte enables, one-cycle registered read and
// a runtime clear sequence that zeroes one word per cycle.
module ram_sync #(
  parameter int DATA_W        = 32,
  parameter int ADDR_W        = 4,
  parameter int READ_ON_WRITE = 0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clr,
  input  logic                req,
  input  logic                w_en,
  input  logic [DATA_W/8-1:0] be,
  input  logic [ADDR_W-1:0]   address,
  input  logic [DATA_W-1:0]   data_input,
  output logic                ready,
  output logic                busy,
  output logic                rd_valid,
  output logic [DATA_W-1:0]   data_output
);

  localparam int   DEPTH = 2 ** ADDR_W;
  localparam int   NB    = DATA_W / 8;
  localparam logic ROW   = (READ_ON_WRITE != 0);

  typedef enum logic {CLEAR, IDLE} state_t;

  state_t            r_state;
  logic [ADDR_W-1:0] r_clr_ptr;
  logic              r_ready;
  logic              r_busy;
  logic              r_rd_valid;

  logic w_acc;
  logic w_wr;
  logic w_rd_upd;
  logic w_clr_we;

  // clr in IDLE takes priority over a same-cycle request, which is dropped
  assign w_acc    = req & r_ready & ~clr & ~rst;
  assign w_wr     = w_acc & w_en;
  assign w_rd_upd = w_acc & (~w_en | ROW);
  assign w_clr_we = (r_state == CLEAR) & ~rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= CLEAR;
      r_clr_ptr <= '0;
      r_ready   <= 1'b0;
      r_busy    <= 1'b1;
    end else begin
      case (r_state)
        CLEAR: begin
          r_clr_ptr <= r_clr_ptr + 1'b1;
          if (r_clr_ptr == ADDR_W'(DEPTH - 1)) begin
            r_state <= IDLE;
            r_ready <= 1'b1;
            r_busy  <= 1'b0;
          end
        end
        IDLE: begin
          if (clr) begin
            r_state   <= CLEAR;
            r_clr_ptr <= '0;
            r_ready   <= 1'b0;
            r_busy    <= 1'b1;
          end
        end
        default: begin
          r_state <= CLEAR;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_valid <= 1'b0;
    end else begin
      r_rd_valid <= w_rd_upd;
    end
  end

  // One byte-wide memory per lane; a write-with-readback returns new bytes for
  // enabled lanes and the stored bytes for the others.
  genvar gi;
  generate
    for (gi = 0; gi < NB; gi++) begin : g_lane
      logic [7:0] r_mem [DEPTH];
      logic [7:0] r_q;

      always_ff @(posedge clk) begin
        if (w_clr_we) begin
          r_mem[r_clr_ptr] <= '0;
        end else if (w_wr && be[gi]) begin
          r_mem[address] <= data_input[gi*8 +: 8];
        end
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          r_q <= '0;
        end else if (w_rd_upd) begin
          r_q <= (w_en && be[gi]) ? data_input[gi*8 +: 8] : r_mem[address];
        end
      end

      assign data_output[gi*8 +: 8] = r_q;
    end
  endgenerate

  assign ready    = r_ready;
  assign busy     = r_busy;
  assign rd_valid = r_rd_valid;

endmodule

// File: tb/tb_ram_sync.sv
// Scoreboard bench for ram_sync: one instance without and one with write readback,
// both driven by the same stimulus and checked against a word-level memory model.
module tb_ram_sync;

  logic        clk = 1'b0;
  logic        rst, clr, req, w_en;
  logic [3:0]  be;
  logic [3:0]  address;
  logic [31:0] data_input;

  logic        ready0, busy0, rd_valid0;
  logic [31:0] dout0;
  logic        ready1, busy1, rd_valid1;
  logic [31:0] dout1;

  int total = 0;
  int bad   = 0;

  logic [31:0] m_mem [16];
  int          m_cnt;
  logic [31:0] exp0[$];
  logic [31:0] exp1[$];

  always #5 clk = ~clk;

  ram_sync #(.DATA_W(32), .ADDR_W(4), .READ_ON_WRITE(0)) dut0 (
    .clk(clk), .rst(rst), .clr(clr), .req(req), .w_en(w_en), .be(be),
    .address(address), .data_input(data_input),
    .ready(ready0), .busy(busy0), .rd_valid(rd_valid0), .data_output(dout0)
  );

  ram_sync #(.DATA_W(32), .ADDR_W(4), .READ_ON_WRITE(1)) dut1 (
    .clk(clk), .rst(rst), .clr(clr), .req(req), .w_en(w_en), .be(be),
    .address(address), .data_input(data_input),
    .ready(ready1), .busy(busy1), .rd_valid(rd_valid1), .data_output(dout1)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic zero_model();
    for (int i = 0; i < 16; i++) m_mem[i] = '0;
  endtask

  // Drive one cycle of inputs, advance the model at the edge, then check the handshake.
  task automatic step(input logic r, input logic c, input logic q, input logic w,
                      input logic [3:0] b, input logic [3:0] a, input logic [31:0] d);
    logic [31:0] merged;
    rst = r; clr = c; req = q; w_en = w; be = b; address = a; data_input = d;
    @(posedge clk);
    if (r) begin
      m_cnt = 16;
      zero_model();
    end else if (m_cnt > 0) begin
      m_cnt--;
    end else if (c) begin
      m_cnt = 16;
      zero_model();
    end else if (q) begin
      if (w) begin
        merged = m_mem[a];
        for (int i = 0; i < 4; i++)
          if (b[i]) merged[i*8 +: 8] = d[i*8 +: 8];
        m_mem[a] = merged;
        exp1.push_back(merged);
      end else begin
        exp0.push_back(m_mem[a]);
        exp1.push_back(m_mem[a]);
      end
    end
    #1;
    chk("ready0", {31'd0, ready0}, {31'd0, m_cnt == 0});
    chk("busy0",  {31'd0, busy0},  {31'd0, m_cnt != 0});
    chk("ready1", {31'd0, ready1}, {31'd0, m_cnt == 0});
    chk("busy1",  {31'd0, busy1},  {31'd0, m_cnt != 0});
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 4'h0, 4'h0, 32'h0);
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d, input logic [3:0] b);
    step(0, 0, 1, 1, b, a, d);
  endtask

  task automatic rd(input logic [3:0] a);
    step(0, 0, 1, 0, 4'h0, a, 32'h0);
  endtask

  // Monitor: every rd_valid pulse must match the oldest expected word.
  always @(negedge clk) begin
    logic [31:0] e;
    if (rd_valid0) begin
      if (exp0.size() == 0) chk("rd_valid0_unexpected", {31'd0, rd_valid0}, 32'd0);
      else begin
        e = exp0.pop_front();
        $display("dut0 read data=%h expected=%h", dout0, e);
        chk("data0", dout0, e);
      end
    end
    if (rd_valid1) begin
      if (exp1.size() == 0) chk("rd_valid1_unexpected", {31'd0, rd_valid1}, 32'd0);
      else begin
        e = exp1.pop_front();
        $display("dut1 read data=%h expected=%h", dout1, e);
        chk("data1", dout1, e);
      end
    end
  end

  initial begin
    rst = 1; clr = 0; req = 0; w_en = 0; be = 0; address = 0; data_input = 0;
    m_cnt = 16;
    zero_model();

    // Reset state
    step(1, 0, 0, 0, 4'h0, 4'h0, 32'h0);
    chk("rst_rd_valid0", {31'd0, rd_valid0}, 32'd0);
    chk("rst_dout0", dout0, 32'd0);
    chk("rst_dout1", dout1, 32'd0);
    step(1, 0, 1, 1, 4'hF, 4'h2, 32'hFFFF_FFFF);
    idle(16);
    for (int a = 0; a < 16; a++) rd(4'(a));

    // Write then read back, including the cycle right after the write
    wr(4'd12, 32'hDEADBEEF, 4'hF);
    rd(4'd12);
    // Partial write over an existing word
    wr(4'd3, 32'hAABBCCDD, 4'hF);
    wr(4'd3, 32'h11223344, 4'b0101);
    rd(4'd3);
    // Readback of the merged word on the READ_ON_WRITE instance
    wr(4'd5, 32'h12345678, 4'hF);
    wr(4'd5, 32'h000000FF, 4'b0001);
    rd(4'd5);
    // Write with no byte enables leaves memory alone
    wr(4'd12, 32'h0BAD0BAD, 4'h0);
    rd(4'd12);

    // Clear beats a same-cycle write; requests during the clear are dropped
    step(0, 1, 1, 1, 4'hF, 4'd12, 32'hCAFEF00D);
    for (int i = 0; i < 16; i++) step(0, (i == 3), 1, 0, 4'h0, 4'd12, 32'h0);
    rd(4'd12);

    // Reset in the middle of a clear restarts it
    wr(4'd7, 32'h77777777, 4'hF);
    step(0, 1, 0, 0, 4'h0, 4'h0, 32'h0);
    idle(6);
    step(1, 0, 0, 0, 4'h0, 4'h0, 32'h0);
    idle(16);
    rd(4'd7);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 199) == 0, $urandom_range(0, 49) == 0,
           $urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
           4'($urandom), 4'($urandom), $urandom);
    end
    for (int i = 0; i < 20 && m_cnt > 0; i++) idle(1);
    for (int a = 0; a < 16; a++) rd(4'(a));
    idle(3);

    chk("exp0_drained", exp0.size(), 32'd0);
    chk("exp1_drained", exp1.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
